// File: rtl/gsim_band_solver.sv
// rtl/gsim_band_solver.sv - Gauss-Seidel solver for a symmetric banded Toeplitz system
module gsim_band_solver #(
    parameter int              N      = 16,
    parameter int              B_W    = 16,
    parameter int              X_W    = 32,
    parameter int              FRAC   = 16,
    parameter int              ITER_W = 8,
    parameter int              A0     = 20,
    parameter int              A1     = -13,
    parameter int              A2     = 6,
    parameter int              A3     = -1,
    parameter logic [31:0]     RECIP  = 32'h0CCCCCCD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [B_W-1:0]       b_in,
    input  logic [ITER_W-1:0]    iter_cnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [X_W-1:0]       x_out,
    output logic                 out_last,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    // Wide enough that b<<FRAC minus the neighbour sum, times RECIP, never wraps.
    localparam int WW = X_W + 48;

    localparam logic signed [WW-1:0] RECIP_W = WW'(RECIP);
    localparam logic signed [WW-1:0] C1      = WW'(A1);
    localparam logic signed [WW-1:0] C2      = WW'(A2);
    localparam logic signed [WW-1:0] C3      = WW'(A3);
    localparam logic signed [WW-1:0] XMAX_W  = {{(WW-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
    localparam logic signed [WW-1:0] XMIN_W  = ~XMAX_W;

    typedef enum logic [1:0] {S_LOAD, S_ITER, S_OUT} state_t;

    state_t state, state_nxt;

    logic signed [B_W-1:0] b_mem [N];
    logic signed [X_W-1:0] x_mem [N];
    logic [IW-1:0]         k, row, idx;
    logic [ITER_W-1:0]     sweep, cnt_q;
    logic [IW-1:0]         lo_i, hi_i;
    logic signed [WW-1:0]  coef, acc, num;
    logic signed [X_W-1:0] row_val, load_val;

    // Division by A0 as a multiply by its reciprocal; arithmetic shift floors.
    function automatic logic signed [WW-1:0] div_a0(input logic signed [WW-1:0] v);
        logic signed [WW-1:0] p;
        p = v * RECIP_W;
        return p >>> 32;
    endfunction

    function automatic logic signed [X_W-1:0] sat_x(input logic signed [WW-1:0] v);
        if (v > XMAX_W)
            return {1'b0, {(X_W-1){1'b1}}};
        else if (v < XMIN_W)
            return {1'b1, {(X_W-1){1'b0}}};
        else
            return v[X_W-1:0];
    endfunction

    // Row update: neighbour sum over the band, out-of-range neighbours contribute nothing.
    always_comb begin
        acc  = '0;
        coef = '0;
        lo_i = '0;
        hi_i = '0;
        for (int d = 1; d <= 3; d++) begin
            coef = (d == 1) ? C1 : ((d == 2) ? C2 : C3);
            lo_i = row - IW'(d);
            hi_i = row + IW'(d);
            if (int'(row) >= d)
                acc = acc + coef * WW'(x_mem[lo_i]);
            if (int'(row) + d <= N - 1)
                acc = acc + coef * WW'(x_mem[hi_i]);
        end
        num      = (WW'(b_mem[row]) <<< FRAC) - acc;
        row_val  = sat_x(div_a0(num));
        load_val = sat_x(div_a0(WW'($signed(b_in)) <<< FRAC));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_LOAD;
        else
            state <= state_nxt;
    end

    // Next-state decode and handshake/output drive.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        x_out     = '0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && k == IW'(N - 1))
                    state_nxt = (cnt_q == '0) ? S_OUT : S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (row == IW'(N - 1) && sweep == cnt_q - ITER_W'(1))
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                x_out     = x_mem[idx];
                out_last  = (idx == IW'(N - 1));
                if (out_ready && idx == IW'(N - 1))
                    state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Storage and counters: load writes B/X, sweeps rewrite X in place, output walks idx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                b_mem[i] <= '0;
                x_mem[i] <= '0;
            end
            k     <= '0;
            row   <= '0;
            idx   <= '0;
            sweep <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    row   <= '0;
                    sweep <= '0;
                    idx   <= '0;
                    if (in_valid) begin
                        b_mem[k] <= $signed(b_in);
                        x_mem[k] <= load_val;
                        if (k == '0)
                            cnt_q <= iter_cnt;
                        k <= (k == IW'(N - 1)) ? '0 : k + IW'(1);
                    end
                end
                S_ITER: begin
                    x_mem[row] <= row_val;
                    if (row == IW'(N - 1)) begin
                        row   <= '0;
                        sweep <= sweep + ITER_W'(1);
                    end else begin
                        row <= row + IW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready)
                        idx <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_band_solver.sv
// tb/tb_gsim_band_solver.sv - randomized self-checking bench for gsim_band_solver
module tb_gsim_band_solver;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] b_in = '0;
    logic [7:0]  iter_cnt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] x_out;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int                 b_vec [N];
    logic signed [31:0] exp_x [N];
    int                 coefs [4] = '{20, -13, 6, -1};

    localparam logic signed [127:0] RECIP_M = 128'h0CCCCCCD;
    localparam logic signed [127:0] XMAX    = 128'sd2147483647;
    localparam logic signed [127:0] XMIN    = -XMAX - 128'sd1;

    gsim_band_solver dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b_in      (b_in),
        .iter_cnt  (iter_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic signed [127:0] mdiv(input logic signed [127:0] v);
        return (v * RECIP_M) >>> 32;
    endfunction

    function automatic logic signed [127:0] msat(input logic signed [127:0] v);
        if (v > XMAX) return XMAX;
        if (v < XMIN) return XMIN;
        return v;
    endfunction

    // Reference solve: straightforward Gauss-Seidel on an array of wide integers.
    task automatic model_solve(input int cnt);
        logic signed [127:0] xm [N];
        logic signed [127:0] bb, acc, c;
        for (int i = 0; i < N; i++) begin
            bb = b_vec[i];
            xm[i] = msat(mdiv(bb * 65536));
        end
        for (int s = 0; s < cnt; s++) begin
            for (int r = 0; r < N; r++) begin
                acc = 0;
                for (int d = 1; d <= 3; d++) begin
                    c = coefs[d];
                    if (r - d >= 0) acc = acc + c * xm[r - d];
                    if (r + d <= N - 1) acc = acc + c * xm[r + d];
                end
                bb = b_vec[r];
                xm[r] = msat(mdiv(bb * 65536 - acc));
            end
        end
        for (int i = 0; i < N; i++) exp_x[i] = xm[i][31:0];
    endtask

    // Streams b_vec in with random gaps; iter_cnt is scrambled after the first handshake.
    task automatic load_vec(input int cnt);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                b_in     = 16'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            b_in     = 16'(b_vec[k]);
            if (k == 0) iter_cnt = 8'(cnt);
            @(posedge clk);
            #1;
            if (k == 0) iter_cnt = 8'($urandom);
        end
    endtask

    // Drains N words; mode 0 always ready, 1 repeating 1-0-0-1, 2 random.
    task automatic collect(input int mode, input string name);
        int          got = 0;
        int          cyc = 0;
        int          pi = 0;
        logic        stalled = 1'b0;
        logic [31:0] px = '0;
        logic        pl = 1'b0;
        int          pat [4] = '{1, 0, 0, 1};
        while (got < N && cyc < N * 8 + 20) begin
            if (stalled) begin
                checks++;
                if (x_out !== px || out_last !== pl) begin
                    errors++;
                    $display("FAIL %s stall_hold idx=%0d got x=%h last=%b want x=%h last=%b",
                             name, got, x_out, out_last, px, pl);
                end
            end
            case (mode)
                0: out_ready = 1'b1;
                1: begin out_ready = pat[pi % 4] != 0; pi++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s out_valid_drop idx=%0d got %b want 1", name, got, out_valid);
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (x_out !== exp_x[got] || out_last !== (got == N - 1)) begin
                    errors++;
                    $display("FAIL %s word idx=%0d got x=%h last=%b want x=%h last=%b",
                             name, got, x_out, out_last, exp_x[got], got == N - 1);
                end
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                px = x_out;
                pl = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (got != N) begin
            errors++;
            $display("FAIL %s drain_timeout got %0d words want %0d", name, got, N);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s rearm got valid=%b ready=%b want valid=0 ready=1",
                     name, out_valid, in_ready);
        end
    endtask

    // Full solve: load, latency measurement (with stray in_valid/out_ready), drain.
    task automatic run_solve(input int cnt, input int mode, input string name);
        int lat = 0;
        model_solve(cnt);
        load_vec(cnt);
        out_ready = 1'b1;
        while (lat < cnt * N + 50) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) begin
                in_valid = 1'b0;
                break;
            end
            in_valid = 1'b1;
            b_in     = 16'($urandom);
        end
        in_valid = 1'b0;
        checks++;
        if (lat != cnt * N + 1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, cnt * N + 1);
        end
        if (out_valid === 1'b1) collect(mode, name);
    endtask

    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            busy !== 1'b0 || x_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b last=%b busy=%b x=%h want 1 0 0 0 0",
                     in_ready, out_valid, out_last, busy, x_out);
        end
    endtask

    task automatic test_all_twenty;
        for (int i = 0; i < N; i++) b_vec[i] = 20;
        run_solve(0, 0, "all_twenty");
    endtask

    task automatic test_impulse;
        for (int i = 0; i < N; i++) b_vec[i] = (i == 0) ? 20 : 0;
        run_solve(1, 0, "impulse");
    endtask

    task automatic test_zero_long;
        for (int i = 0; i < N; i++) b_vec[i] = 0;
        run_solve(120, 2, "zero_long");
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < N; i++) b_vec[i] = int'($signed(16'($urandom)));
        run_solve(3, 1, "backpressure");
    endtask

    task automatic test_reset_mid_iter;
        for (int i = 0; i < N; i++) b_vec[i] = int'($signed(16'($urandom)));
        load_vec(50);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            busy !== 1'b0 || x_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b vld=%b last=%b busy=%b x=%h want 1 0 0 0 0",
                     in_ready, out_valid, out_last, busy, x_out);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) b_vec[i] = 20;
        run_solve(0, 0, "after_reset");
    endtask

    task automatic test_saturation;
        for (int i = 0; i < N; i++) b_vec[i] = (i == 0) ? 32767 : -32768;
        run_solve(255, 0, "saturation");
    endtask

    task automatic test_random;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) b_vec[i] = int'($signed(16'($urandom)));
            run_solve(int'($urandom_range(0, 5)), 2, "random");
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        reset = 1'b1;
        test_all_twenty;
        test_impulse;
        test_zero_long;
        test_backpressure;
        test_reset_mid_iter;
        test_saturation;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
